core_run_ctrl: RTL and testbench

//  Run controller for the single-cycle RV32I core. Loads program memory through a valid/ready

---
 rtl/rv_ctrl_pkg.sv | 31 +++
 rtl/core_run_ctrl_halt_detect.sv | 52 +++++
 rtl/core_run_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_core_run_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the RV32I run controller: FSM state codes, halt causes
// and the two instruction encodings that stop the core.
package rv_ctrl_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd2;
    localparam logic [2:0] ST_STEP = 3'd3;
    localparam logic [2:0] ST_HALT = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_LOAD = ST_LOAD,
        S_RUN  = ST_RUN,
        S_STEP = ST_STEP,
        S_HALT = ST_HALT
    } state_t;

    localparam logic [1:0] HALT_NONE  = 2'd0;
    localparam logic [1:0] HALT_BRK   = 2'd1;
    localparam logic [1:0] HALT_LIMIT = 2'd2;
    localparam logic [1:0] HALT_EXT   = 2'd3;

    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSTR_SELFJ  = 32'h0000_006F;

    function automatic logic is_stop_instr(input logic [31:0] instr);
        return (instr == INSTR_EBREAK) || (instr == INSTR_SELFJ);
    endfunction

endpackage

// File: rtl/core_run_ctrl_halt_detect.sv
// Combinational halt detection for the run controller: ebreak / self-jump /
// breakpoint, cycle limit and external request, priority encoded into a cause.
module halt_detect
    import rv_ctrl_pkg::*;
#(
    parameter int          CNT_W   = 32,
    parameter logic [31:0] MAX_CYC = 32'hFFFF
) (
    input  logic [31:0]      i_instr,
    input  logic [31:0]      i_pc,
    input  logic             i_bp_en,
    input  logic [31:0]      i_bp_pc,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic             i_halt_req,
    output logic             o_instr_stop,
    output logic             o_no_retire,
    output logic             o_halt,
    output logic [1:0]       o_cause
);

    logic w_stop;
    logic w_bp_hit;
    logic w_limit;

    assign w_stop   = is_stop_instr(i_instr);
    assign w_bp_hit = i_bp_en && (i_pc == i_bp_pc);
    // The limit fires on the retiring cycle that brings the count up to MAX_CYC.
    assign w_limit  = (MAX_CYC != 32'd0) && (i_cnt == CNT_W'(MAX_CYC - 32'd1));

    assign o_instr_stop = w_stop;
    assign o_no_retire  = w_stop || w_bp_hit;

    // Priority encode the halt reasons: stop instruction > cycle limit > external.
    always_comb begin
        o_halt  = 1'b0;
        o_cause = HALT_NONE;
        if (w_stop || w_bp_hit) begin
            o_halt  = 1'b1;
            o_cause = HALT_BRK;
        end else if (w_limit) begin
            o_halt  = 1'b1;
            o_cause = HALT_LIMIT;
        end else if (i_halt_req) begin
            o_halt  = 1'b1;
            o_cause = HALT_EXT;
        end else begin
            o_halt  = 1'b0;
            o_cause = HALT_NONE;
        end
    end

endmodule

// File: rtl/core_run_ctrl.sv
// Run controller: loads program memory over a valid/ready stream and gates the core
// clock enable (free-run / single-step / halt). Define RUN_BREAKPOINT_EN to add bp_en/bp_pc.
module core_run_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int          PM_AW   = 10,
    parameter int          CNT_W   = 32,
    parameter logic [31:0] MAX_CYC = 32'hFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [PM_AW-1:0] load_addr,
    input  logic [31:0]      load_data,
    input  logic             load_last,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             halt_req,
    input  logic [31:0]      core_pc,
    input  logic [31:0]      core_instr,
`ifdef RUN_BREAKPOINT_EN
    input  logic             bp_en,
    input  logic [31:0]      bp_pc,
`endif
    output logic             core_en,
    output logic             pm_we,
    output logic [PM_AW-1:0] pm_addr,
    output logic [31:0]      pm_wdata,
    output logic [2:0]       state_o,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] cycle_cnt
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_core_en;
    logic             w_cnt_clr;
    logic [1:0]       w_cause_nxt;
    logic [1:0]       r_halt_cause;
    logic             w_xfer;
    logic             r_pm_we;
    logic [PM_AW-1:0] r_pm_addr;
    logic [31:0]      r_pm_wdata;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic             w_bp_en;
    logic [31:0]      w_bp_pc;
    logic             w_instr_stop;
    logic             w_no_retire;
    logic             w_halt;
    logic [1:0]       w_hd_cause;

`ifdef RUN_BREAKPOINT_EN
    assign w_bp_en = bp_en;
    assign w_bp_pc = bp_pc;
`else
    assign w_bp_en = 1'b0;
    assign w_bp_pc = 32'h0000_0000;
`endif

    halt_detect #(
        .CNT_W   (CNT_W),
        .MAX_CYC (MAX_CYC)
    ) u_halt_detect (
        .i_instr      (core_instr),
        .i_pc         (core_pc),
        .i_bp_en      (w_bp_en),
        .i_bp_pc      (w_bp_pc),
        .i_cnt        (r_cycle_cnt),
        .i_halt_req   (halt_req),
        .o_instr_stop (w_instr_stop),
        .o_no_retire  (w_no_retire),
        .o_halt       (w_halt),
        .o_cause      (w_hd_cause)
    );

    assign w_xfer = (r_state == S_LOAD) && load_valid;

    // Next-state, core enable and halt-cause decode.
    always_comb begin
        w_state_nxt = r_state;
        w_core_en   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cause_nxt = r_halt_cause;
        case (r_state)
            S_IDLE: begin
                if (load_valid) begin
                    w_state_nxt = S_LOAD;
                end else if (run_req) begin
                    w_state_nxt = S_RUN;
                    w_cnt_clr   = 1'b1;
                    w_cause_nxt = HALT_NONE;
                end else if (step_req) begin
                    w_state_nxt = S_STEP;
                    w_cnt_clr   = 1'b1;
                    w_cause_nxt = HALT_NONE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOAD: begin
                if (load_valid && load_last) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_RUN: begin
                w_core_en = ~w_no_retire;
                if (w_halt) begin
                    w_state_nxt = S_HALT;
                    w_cause_nxt = w_hd_cause;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_STEP: begin
                // A step never sees the breakpoint, so it can walk off one.
                w_core_en   = ~w_instr_stop;
                w_state_nxt = S_HALT;
                if (w_instr_stop) begin
                    w_cause_nxt = HALT_BRK;
                end else begin
                    w_cause_nxt = HALT_NONE;
                end
            end
            S_HALT: begin
                if (load_valid) begin
                    w_state_nxt = S_LOAD;
                    w_cnt_clr   = 1'b1;
                end else if (run_req) begin
                    w_state_nxt = S_RUN;
                    w_cnt_clr   = 1'b1;
                    w_cause_nxt = HALT_NONE;
                end else if (step_req) begin
                    w_state_nxt = S_STEP;
                    w_cause_nxt = HALT_NONE;
                end else begin
                    w_state_nxt = S_HALT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and halt-cause registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_halt_cause <= HALT_NONE;
        end else begin
            r_state      <= w_state_nxt;
            r_halt_cause <= w_cause_nxt;
        end
    end

    // Retired-instruction counter, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cycle_cnt <= '0;
        end else if (w_core_en && (r_cycle_cnt != {CNT_W{1'b1}})) begin
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
        end else begin
            r_cycle_cnt <= r_cycle_cnt;
        end
    end

    // Program-memory write stage: one cycle behind each accepted load word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pm_we    <= 1'b0;
            r_pm_addr  <= '0;
            r_pm_wdata <= 32'h0000_0000;
        end else if (w_xfer) begin
            r_pm_we    <= 1'b1;
            r_pm_addr  <= load_addr;
            r_pm_wdata <= load_data;
        end else begin
            r_pm_we    <= 1'b0;
            r_pm_addr  <= r_pm_addr;
            r_pm_wdata <= r_pm_wdata;
        end
    end

    assign load_ready = (r_state == S_LOAD);
    assign core_en    = w_core_en;
    assign pm_we      = r_pm_we;
    assign pm_addr    = r_pm_addr;
    assign pm_wdata   = r_pm_wdata;
    assign state_o    = r_state;
    assign halt_cause = r_halt_cause;
    assign cycle_cnt  = r_cycle_cnt;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Scoreboard bench for core_run_ctrl: a tiny PC/program-memory model feeds the core side,
// expected writes, halts and state snapshots are queued and checked by a monitor.
module tb_core_run_ctrl;
    import rv_ctrl_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [1:0]  cause;
        logic [31:0] cnt;
        int          en;
        logic [31:0] pc;
    } halt_t;

    typedef struct {
        logic [2:0]  st;
        logic        en;
        logic        rdy;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [1:0]  cause;
        logic        chkc;
        logic [31:0] cnt;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic [9:0]  load_addr = 10'd0;
    logic [31:0] load_data = 32'd0;
    logic        load_last = 1'b0;
    logic        run_req = 1'b0;
    logic        step_req = 1'b0;
    logic        halt_req = 1'b0;
    logic [31:0] core_pc;
    logic [31:0] core_instr;
`ifdef RUN_BREAKPOINT_EN
    logic        bp_en = 1'b0;
    logic [31:0] bp_pc = 32'd0;
`endif
    logic        load_ready;
    logic        core_en;
    logic        pm_we;
    logic [9:0]  pm_addr;
    logic [31:0] pm_wdata;
    logic [2:0]  state_o;
    logic [1:0]  halt_cause;
    logic [31:0] cycle_cnt;

    logic [31:0] pc = 32'd0;
    logic [31:0] mem [0:1023];
    logic        set_pc_req = 1'b0;
    logic [31:0] set_pc_val = 32'd0;
    logic        tmo = 1'b0;
    logic        done = 1'b0;

    logic [41:0] q_wr [$];
    halt_t       q_halt [$];
    snap_t       q_snap [$];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    core_run_ctrl #(.PM_AW(10), .CNT_W(32), .MAX_CYC(32'd5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_last  (load_last),
        .run_req    (run_req),
        .step_req   (step_req),
        .halt_req   (halt_req),
        .core_pc    (core_pc),
        .core_instr (core_instr),
`ifdef RUN_BREAKPOINT_EN
        .bp_en      (bp_en),
        .bp_pc      (bp_pc),
`endif
        .core_en    (core_en),
        .pm_we      (pm_we),
        .pm_addr    (pm_addr),
        .pm_wdata   (pm_wdata),
        .state_o    (state_o),
        .halt_cause (halt_cause),
        .cycle_cnt  (cycle_cnt)
    );

    // Core-side model: program memory and a PC that advances on every enabled cycle.
    assign core_pc    = pc;
    assign core_instr = mem[pc[11:2]];

    always @(posedge clk) begin
        if (pm_we) mem[pm_addr] <= pm_wdata;
    end

    always @(posedge clk) begin
        if (set_pc_req) pc <= set_pc_val;
        else if (core_en) pc <= pc + 32'd4;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops and compares whenever the DUT writes memory, enters HALT or a snapshot is due.
    initial begin : monitor
        int          en_cnt;
        logic [2:0]  prev_st;
        logic [41:0] w;
        halt_t       h;
        snap_t       s;
        en_cnt  = 0;
        prev_st = 3'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                en_cnt  = 0;
                prev_st = 3'd0;
            end else begin
                if (core_en) en_cnt++;
                if (pm_we) begin
                    if (q_wr.size() == 0) begin
                        chk("unexpected_pm_we", 64'(1), 64'(0));
                    end else begin
                        w = q_wr.pop_front();
                        chk("pm_addr", 64'(pm_addr), 64'(w[41:32]));
                        chk("pm_wdata", 64'(pm_wdata), 64'(w[31:0]));
                    end
                end
                if (state_o == ST_HALT && prev_st != ST_HALT) begin
                    if (q_halt.size() == 0) begin
                        chk("unexpected_halt", 64'(1), 64'(0));
                    end else begin
                        h = q_halt.pop_front();
                        chk("halt_cause", 64'(halt_cause), 64'(h.cause));
                        chk("halt_cycle_cnt", 64'(cycle_cnt), 64'(h.cnt));
                        chk("halt_core_en_cycles", 64'(en_cnt), 64'(h.en));
                        chk("halt_core_pc", 64'(core_pc), 64'(h.pc));
                    end
                    en_cnt = 0;
                end
                prev_st = state_o;
            end
            if (q_snap.size() > 0) begin
                s = q_snap.pop_front();
                chk("snap_state", 64'(state_o), 64'(s.st));
                chk("snap_core_en", 64'(core_en), 64'(s.en));
                chk("snap_load_ready", 64'(load_ready), 64'(s.rdy));
                chk("snap_pm_we", 64'(pm_we), 64'(s.we));
                chk("snap_pm_addr", 64'(pm_addr), 64'(s.addr));
                chk("snap_pm_wdata", 64'(pm_wdata), 64'(s.wdata));
                chk("snap_cycle_cnt", 64'(cycle_cnt), 64'(s.cnt));
                if (s.chkc) chk("snap_halt_cause", 64'(halt_cause), 64'(s.cause));
            end
            if (done) begin
                chk("wait_timeout", 64'(tmo), 64'(0));
                chk("writes_left", 64'(q_wr.size()), 64'(0));
                chk("halts_left", 64'(q_halt.size()), 64'(0));
                chk("snaps_left", 64'(q_snap.size()), 64'(0));
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic snap(input logic [2:0] st, input logic en, input logic rdy, input logic we,
                        input logic [9:0] addr, input logic [31:0] wd, input logic [1:0] cause,
                        input logic chkc, input logic [31:0] cnt);
        snap_t s;
        s.st = st; s.en = en; s.rdy = rdy; s.we = we; s.addr = addr;
        s.wdata = wd; s.cause = cause; s.chkc = chkc; s.cnt = cnt;
        #2;
        q_snap.push_back(s);
        @(negedge clk);
    endtask

    task automatic exp_halt(input logic [1:0] cause, input logic [31:0] cnt, input int en,
                            input logic [31:0] hpc);
        halt_t h;
        h.cause = cause; h.cnt = cnt; h.en = en; h.pc = hpc;
        q_halt.push_back(h);
    endtask

    task automatic load_word(input logic [9:0] a, input logic [31:0] d, input logic last);
        int n;
        n = 0;
        q_wr.push_back({a, d});
        load_valid = 1'b1;
        load_addr  = a;
        load_data  = d;
        load_last  = last;
        while (!load_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!load_ready) tmo = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic set_pc(input logic [31:0] v);
        set_pc_val = v;
        set_pc_req = 1'b1;
        @(negedge clk);
        set_pc_req = 1'b0;
    endtask

    task automatic pulse_run();
        @(negedge clk);
        run_req = 1'b1;
        @(negedge clk);
        run_req = 1'b0;
    endtask

    task automatic pulse_step();
        @(negedge clk);
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
    endtask

    task automatic wait_halt();
        int n;
        n = 0;
        while (state_o != ST_HALT && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (state_o != ST_HALT) tmo = 1'b1;
    endtask

    // Directed stimulus; every expected value is hand-derived from the image contents.
    initial begin : stim
        snap(ST_IDLE, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0, HALT_NONE, 1'b1, 32'd0);
        rst_n = 1'b1;

        load_word(10'd0, 32'h0C30_0093, 1'b0);
        load_word(10'd1, 32'h0AA0_0113, 1'b0);
        load_word(10'd2, INSTR_EBREAK, 1'b1);
        snap(ST_IDLE, 1'b0, 1'b0, 1'b0, 10'd2, INSTR_EBREAK, HALT_NONE, 1'b1, 32'd0);

        exp_halt(HALT_BRK, 32'd2, 2, 32'd8);
        pulse_run();
        wait_halt();
        exp_halt(HALT_BRK, 32'd0, 0, 32'd8);
        pulse_run();
        wait_halt();

        load_word(10'd0, 32'h0C30_0093, 1'b0);
        load_word(10'd1, INSTR_SELFJ, 1'b1);
        set_pc(32'd0);
        exp_halt(HALT_BRK, 32'd1, 1, 32'd4);
        pulse_run();
        wait_halt();

        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                run_req  = 1'b1;
                step_req = 1'b1;
            end
            load_word(10'(i), (i == 7) ? INSTR_EBREAK : NOP, (i == 7));
            run_req  = 1'b0;
            step_req = 1'b0;
            if (i == 3) snap(ST_LOAD, 1'b0, 1'b1, 1'b0, 10'd3, NOP, HALT_NONE, 1'b0, 32'd0);
        end

        set_pc(32'd0);
        exp_halt(HALT_LIMIT, 32'd5, 5, 32'd20);
        pulse_run();
        wait_halt();

        set_pc(32'd28);
        exp_halt(HALT_BRK, 32'd0, 0, 32'd28);
        pulse_run();
        wait_halt();

        set_pc(32'd0);
        for (int k = 1; k <= 3; k++) begin
            exp_halt(HALT_NONE, 32'(k), 1, 32'(4 * k));
            pulse_step();
            wait_halt();
        end

        set_pc(32'd0);
        exp_halt(HALT_EXT, 32'd2, 2, 32'd8);
        pulse_run();
        @(negedge clk);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        wait_halt();

        @(negedge clk);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        snap(ST_HALT, 1'b0, 1'b0, 1'b0, 10'd7, INSTR_EBREAK, HALT_EXT, 1'b1, 32'd2);

        set_pc(32'd0);
        pulse_run();
        @(negedge clk);
        rst_n = 1'b0;
        snap(ST_IDLE, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0, HALT_NONE, 1'b1, 32'd0);
        rst_n = 1'b1;

`ifdef RUN_BREAKPOINT_EN
        set_pc(32'd0);
        bp_en = 1'b1;
        bp_pc = 32'd8;
        exp_halt(HALT_BRK, 32'd2, 2, 32'd8);
        pulse_run();
        wait_halt();
        bp_en = 1'b0;
`endif

        repeat (2) @(negedge clk);
        done = 1'b1;
    end

endmodule
